// File: rtl/traffic_cfg_pkg.sv
// Shared types and constants for the traffic-light timing configuration path.
// Latency: n/a (types and pure functions only). Backpressure: n/a.
// Used by traffic_time_setter and by the traffic_light controller it feeds.
package traffic_cfg_pkg;

    localparam int TIME_W = 7;

    localparam logic [TIME_W-1:0] DEF_GREEN  = 7'd25;
    localparam logic [TIME_W-1:0] DEF_YELLOW = 7'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EDIT_G = 2'd1,
        EDIT_Y = 2'd2,
        COMMIT = 2'd3
    } state_e;

    localparam logic [1:0] SEL_IDLE   = 2'd0;
    localparam logic [1:0] SEL_GREEN  = 2'd1;
    localparam logic [1:0] SEL_YELLOW = 2'd2;
    localparam logic [1:0] SEL_COMMIT = 2'd3;

    function automatic logic [1:0] sel_of(input state_e s);
        case (s)
            EDIT_G:  return SEL_GREEN;
            EDIT_Y:  return SEL_YELLOW;
            COMMIT:  return SEL_COMMIT;
            default: return SEL_IDLE;
        endcase
    endfunction

    // Single up/down step that wraps inside [lo, hi].
    function automatic logic [TIME_W-1:0] step_time(input logic [TIME_W-1:0] v,
                                                    input logic              up,
                                                    input logic [TIME_W-1:0] lo,
                                                    input logic [TIME_W-1:0] hi);
        logic [TIME_W-1:0] one;
        one = 1;
        if (up) begin
            return (v >= hi) ? lo : v + one;
        end
        return (v <= lo) ? hi : v - one;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, debounce counter, press pulse.
// Latency: raw edge to press_pulse is 2 + DEB_CYCLES + 1 cycles.
// Backpressure: none; the pulse lasts one cycle and is lost if not consumed.
module btn_debounce #(
    parameter int DEB_CYCLES = 20
) (
    input  logic s_clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press_pulse
);

    localparam int CNT_W = $clog2(DEB_CYCLES + 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             level_dly_q;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count consecutive cycles of disagreement; any agreement restarts the count.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        press_d = level_q & ~level_dly_q;
    end

    always_ff @(posedge s_clk) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            press_q     <= 1'b0;
            cnt_q       <= '0;
        end else begin
            sync1_q     <= btn_raw;
            sync2_q     <= sync1_q;
            level_q     <= level_d;
            level_dly_q <= level_q;
            press_q     <= press_d;
            cnt_q       <= cnt_d;
        end
    end

    assign press_pulse = press_q;

endmodule

// File: rtl/traffic_time_setter.sv
// Button-driven editor for green/yellow durations, committed over valid/ready.
// Latency: button press to shadow update 2 + DEB_CYCLES + 2 cycles; commit 1 cycle after ready.
// Backpressure: COMMIT holds cfg_valid and stable times until cfg_ready; buttons ignored meanwhile.
module traffic_time_setter
    import traffic_cfg_pkg::*;
#(
    parameter int                DEB_CYCLES     = 20,
    parameter int                TIMEOUT_CYCLES = 50_000_000,
    parameter logic [TIME_W-1:0] DEF_GREEN      = traffic_cfg_pkg::DEF_GREEN,
    parameter logic [TIME_W-1:0] DEF_YELLOW     = traffic_cfg_pkg::DEF_YELLOW,
    parameter logic [TIME_W-1:0] MIN_TIME       = 7'd1,
    parameter logic [TIME_W-1:0] MAX_TIME       = 7'd99
) (
    input  logic              s_clk,
    input  logic              rst,
    input  logic              btn_mode,
    input  logic              btn_up,
    input  logic              btn_down,
    input  logic              cfg_ready,
    output logic              cfg_valid,
    output logic [TIME_W-1:0] green_time,
    output logic [TIME_W-1:0] yellow_time,
    output logic [TIME_W-1:0] edit_value,
    output logic [1:0]        edit_sel
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic mode_ev, up_ev, down_ev;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
        .s_clk(s_clk), .rst(rst), .btn_raw(btn_mode), .press_pulse(mode_ev));
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
        .s_clk(s_clk), .rst(rst), .btn_raw(btn_up), .press_pulse(up_ev));
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_down (
        .s_clk(s_clk), .rst(rst), .btn_raw(btn_down), .press_pulse(down_ev));

    state_e            state_q, state_d;
    logic [TIME_W-1:0] green_q, green_d, yellow_q, yellow_d;
    logic [TIME_W-1:0] sh_g_q, sh_g_d, sh_y_q, sh_y_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              cfg_valid_q, cfg_valid_d;
    logic [1:0]        edit_sel_q, edit_sel_d;
    logic              any_ev, up_ok, dn_ok, tmo_hit;

    always_comb begin
        state_d  = state_q;
        green_d  = green_q;
        yellow_d = yellow_q;
        sh_g_d   = sh_g_q;
        sh_y_d   = sh_y_q;
        tmo_d    = '0;
        any_ev   = mode_ev | up_ev | down_ev;
        // mode wins the cycle; simultaneous up and down cancel each other.
        up_ok    = up_ev & ~down_ev & ~mode_ev;
        dn_ok    = down_ev & ~up_ev & ~mode_ev;
        tmo_hit  = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

        case (state_q)
            IDLE: begin
                if (mode_ev) begin
                    state_d = EDIT_G;
                    sh_g_d  = green_q;
                    sh_y_d  = yellow_q;
                end
            end
            EDIT_G, EDIT_Y: begin
                if (mode_ev) begin
                    state_d = (state_q == EDIT_G) ? EDIT_Y : COMMIT;
                end else if (up_ok || dn_ok) begin
                    if (state_q == EDIT_G) begin
                        sh_g_d = step_time(sh_g_q, up_ok, MIN_TIME, MAX_TIME);
                    end else begin
                        sh_y_d = step_time(sh_y_q, up_ok, MIN_TIME, MAX_TIME);
                    end
                end
                if (!any_ev) begin
                    if (tmo_hit) begin
                        state_d = IDLE;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end
            end
            COMMIT: begin
                if (cfg_valid_q && cfg_ready) begin
                    green_d  = sh_g_q;
                    yellow_d = sh_y_q;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        cfg_valid_d = (state_d == COMMIT);
        edit_sel_d  = sel_of(state_d);
    end

    always_ff @(posedge s_clk) begin
        if (rst) begin
            state_q     <= IDLE;
            green_q     <= DEF_GREEN;
            yellow_q    <= DEF_YELLOW;
            sh_g_q      <= DEF_GREEN;
            sh_y_q      <= DEF_YELLOW;
            tmo_q       <= '0;
            cfg_valid_q <= 1'b0;
            edit_sel_q  <= SEL_IDLE;
        end else begin
            state_q     <= state_d;
            green_q     <= green_d;
            yellow_q    <= yellow_d;
            sh_g_q      <= sh_g_d;
            sh_y_q      <= sh_y_d;
            tmo_q       <= tmo_d;
            cfg_valid_q <= cfg_valid_d;
            edit_sel_q  <= edit_sel_d;
        end
    end

    always_comb begin
        edit_value = '0;
        case (state_q)
            EDIT_G:  edit_value = sh_g_q;
            EDIT_Y:  edit_value = sh_y_q;
            default: edit_value = '0;
        endcase
    end

    assign green_time  = (state_q == COMMIT) ? sh_g_q : green_q;
    assign yellow_time = (state_q == COMMIT) ? sh_y_q : yellow_q;
    assign cfg_valid   = cfg_valid_q;
    assign edit_sel    = edit_sel_q;

endmodule

// File: tb/tb_traffic_time_setter.sv
// Directed bench for traffic_time_setter with short debounce and timeout.
module tb_traffic_time_setter;

    logic       s_clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic       cfg_ready = 1'b0;
    logic       cfg_valid;
    logic [6:0] green_time, yellow_time, edit_value;
    logic [1:0] edit_sel;

    int tests = 0;
    int fails = 0;

    traffic_time_setter #(
        .DEB_CYCLES(4),
        .TIMEOUT_CYCLES(200)
    ) dut (
        .s_clk(s_clk),
        .rst(rst),
        .btn_mode(btn_mode),
        .btn_up(btn_up),
        .btn_down(btn_down),
        .cfg_ready(cfg_ready),
        .cfg_valid(cfg_valid),
        .green_time(green_time),
        .yellow_time(yellow_time),
        .edit_value(edit_value),
        .edit_sel(edit_sel)
    );

    always #5 s_clk = ~s_clk;

    task automatic tick(input int n);
        repeat (n) @(posedge s_clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_btn(input int which, input logic v);
        case (which)
            0: btn_mode = v;
            1: btn_up   = v;
            default: btn_down = v;
        endcase
    endtask

    // Clean press: event lands 7 cycles after the edge, shadow updates on the 8th.
    task automatic press(input int which);
        set_btn(which, 1'b1);
        tick(8);
        set_btn(which, 1'b0);
        tick(8);
    endtask

    int exp_dn[5] = '{2, 1, 99, 98, 97};

    initial begin
        // Reset and idle
        tick(3);
        rst = 1'b0;
        tick(50);
        check("rst_green", green_time, 25);
        check("rst_yellow", yellow_time, 3);
        check("rst_valid", cfg_valid, 0);
        check("rst_sel", edit_sel, 0);
        check("rst_edit_value", edit_value, 0);

        press(0);
        check("edit_g_sel", edit_sel, 1);
        check("edit_g_load", edit_value, 25);

        // Bouncy up: two short highs; only the final, held level counts
        btn_up = 1'b1; tick(2);
        btn_up = 1'b0; tick(2);
        btn_up = 1'b1; tick(2);
        btn_up = 1'b0; tick(2);
        btn_up = 1'b1;
        tick(7);
        check("bounce_before_event", edit_value, 25);
        tick(1);
        check("bounce_one_event", edit_value, 26);
        tick(2);
        btn_up = 1'b0;
        tick(12);
        check("bounce_no_release_event", edit_value, 26);

        press(1);
        press(1);
        check("green_up_28", edit_value, 28);

        press(0);
        check("edit_y_sel", edit_sel, 2);
        check("edit_y_load", edit_value, 3);
        for (int i = 0; i < 5; i++) begin
            press(2);
            check($sformatf("yellow_down_%0d", i), edit_value, exp_dn[i]);
        end

        // Commit with ready held low
        cfg_ready = 1'b0;
        press(0);
        check("commit_valid", cfg_valid, 1);
        check("commit_sel", edit_sel, 3);
        check("commit_green", green_time, 28);
        check("commit_yellow", yellow_time, 97);
        check("commit_edit_value", edit_value, 0);
        tick(10);
        check("commit_hold_valid", cfg_valid, 1);
        check("commit_hold_green", green_time, 28);
        cfg_ready = 1'b1;
        tick(1);
        cfg_ready = 1'b0;
        check("hs_valid", cfg_valid, 0);
        check("hs_sel", edit_sel, 0);
        check("hs_green", green_time, 28);
        check("hs_yellow", yellow_time, 97);

        // Timeout after fresh reset
        rst = 1'b1; tick(2); rst = 1'b0; tick(2);
        press(0);
        press(1);
        press(1);
        check("tmo_edit_value", edit_value, 27);
        tick(190);
        check("tmo_not_yet", edit_sel, 1);
        tick(4);
        check("tmo_sel", edit_sel, 0);
        check("tmo_green", green_time, 25);
        check("tmo_valid", cfg_valid, 0);

        // Wrap boundaries on green
        press(0);
        check("wrap_load", edit_value, 25);
        for (int i = 0; i < 74; i++) press(1);
        check("wrap_at_max", edit_value, 99);
        press(1);
        check("wrap_up_to_min", edit_value, 1);
        press(2);
        check("wrap_down_to_max", edit_value, 99);
        btn_up = 1'b1; btn_down = 1'b1;
        tick(8);
        btn_up = 1'b0; btn_down = 1'b0;
        tick(8);
        check("up_down_cancel", edit_value, 99);
        check("up_down_sel", edit_sel, 1);

        // Mode beats a simultaneous up
        btn_mode = 1'b1; btn_up = 1'b1;
        tick(8);
        btn_mode = 1'b0; btn_up = 1'b0;
        tick(8);
        check("mode_prio_sel", edit_sel, 2);
        check("mode_prio_yellow", edit_value, 3);

        // Ready already high when COMMIT is entered
        cfg_ready = 1'b1;
        btn_mode = 1'b1;
        tick(8);
        check("fast_commit_valid", cfg_valid, 1);
        tick(1);
        check("fast_commit_done", cfg_valid, 0);
        check("fast_commit_green", green_time, 99);
        check("fast_commit_yellow", yellow_time, 3);
        btn_mode = 1'b0;
        cfg_ready = 1'b0;
        tick(10);

        // Reset while in COMMIT
        press(0);
        press(0);
        press(0);
        check("pre_rst_valid", cfg_valid, 1);
        rst = 1'b1;
        tick(1);
        check("mid_rst_valid", cfg_valid, 0);
        check("mid_rst_green", green_time, 25);
        check("mid_rst_yellow", yellow_time, 3);
        check("mid_rst_sel", edit_sel, 0);
        rst = 1'b0;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
